baud_gen_prog: RTL and testbench

BAUD_GEN_PROG -- requirements
Module: baud_gen_prog

---
 rtl/baud_gen_prog.sv | 155 +++++++++++++++
 tb/tb_baud_gen_prog.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_prog.sv
// Programmable UART baud generator. A fractional-N period counter produces
// tick_ovs at OVS x baud and tick_bit at baud. Configuration writes are held
// pending and only take effect on a bit boundary or while the generator is
// disabled, so a bit period is never cut short or stretched by a change.
module baud_gen_prog #(
   parameter int CLK_HZ = 100000000,
   parameter int OVS    = 8,
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_wr,
   input  logic              cfg_mode,
   input  logic [1:0]        cfg_sel,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [FRAC_W-1:0] cfg_frac,
   output logic              tick_ovs,
   output logic              tick_bit,
   output logic              cfg_pend,
   output logic [DIV_W-1:0]  act_div,
   output logic [FRAC_W-1:0] act_frac
);

   localparam int DW   = DIV_W + FRAC_W;
   localparam int CW   = DIV_W + 1;
   localparam int PH_W = $clog2(OVS);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);

   // Round-to-nearest fixed-point divisor CLK_HZ*2^FRAC_W/(baud*OVS).
   function automatic logic [DW-1:0] preset_d(input longint baud);
      longint num;
      longint den;
      num = longint'(CLK_HZ) <<< FRAC_W;
      den = baud * longint'(OVS);
      return DW'((2 * num + den) / (2 * den));
   endfunction

   localparam logic [DW-1:0] PRE_0 = preset_d(9600);
   localparam logic [DW-1:0] PRE_1 = preset_d(19200);
   localparam logic [DW-1:0] PRE_2 = preset_d(57600);
   localparam logic [DW-1:0] PRE_3 = preset_d(115200);

   // Turn a mode/select/custom tuple into a packed {div, frac} divisor.
   function automatic logic [DW-1:0] resolve_cfg(input logic              mode,
                                                 input logic [1:0]        sel,
                                                 input logic [DIV_W-1:0]  div,
                                                 input logic [FRAC_W-1:0] frac);
      logic [DW-1:0] d;
      if (mode) begin
         d = {div, frac};
      end else begin
         case (sel)
            2'd0:    d = PRE_0;
            2'd1:    d = PRE_1;
            2'd2:    d = PRE_2;
            default: d = PRE_3;
         endcase
      end
      return d;
   endfunction

   logic [CW-1:0]     cnt;
   logic [CW-1:0]     per_m1;
   logic [PH_W-1:0]   phase;
   logic [FRAC_W-1:0] acc;
   logic              carry;
   logic [FRAC_W:0]   acc_sum;
   logic [DIV_W-1:0]  eff_div;
   logic              period_end;
   logic              bit_end;
   logic              apply;
   logic [DW-1:0]     new_cfg;

   logic              pend_mode;
   logic [1:0]        pend_sel;
   logic [DIV_W-1:0]  pend_div;
   logic [FRAC_W-1:0] pend_frac;

   // Period length (divisor clamped to 2 plus fractional carry), boundary and apply decode.
   always_comb begin
      eff_div    = (act_div < DIV_W'(2)) ? DIV_W'(2) : act_div;
      per_m1     = {1'b0, eff_div} + CW'(carry) - CW'(1);
      acc_sum    = {1'b0, acc} + {1'b0, act_frac};
      period_end = en && (cnt == per_m1);
      bit_end    = period_end && (phase == PH_LAST);
      apply      = cfg_pend && (bit_end || !en);
      new_cfg    = cfg_wr ? resolve_cfg(cfg_mode, cfg_sel, cfg_div, cfg_frac)
                          : resolve_cfg(pend_mode, pend_sel, pend_div, pend_frac);
   end

   // Period counter, phase counter, fractional accumulator and registered ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         phase    <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         tick_ovs <= 1'b0;
         tick_bit <= 1'b0;
      end else if (!en) begin
         cnt      <= '0;
         phase    <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         tick_ovs <= 1'b0;
         tick_bit <= 1'b0;
      end else begin
         tick_ovs <= period_end;
         tick_bit <= bit_end;
         if (period_end) begin
            cnt   <= '0;
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            // A new divisor starts with a clean fractional phase.
            if (apply) begin
               acc   <= '0;
               carry <= 1'b0;
            end else begin
               {carry, acc} <= acc_sum;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Pending-config capture and application to the active divisor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_pend  <= 1'b0;
         act_div   <= PRE_0[DW-1:FRAC_W];
         act_frac  <= PRE_0[FRAC_W-1:0];
         pend_mode <= 1'b0;
         pend_sel  <= 2'd0;
         pend_div  <= '0;
         pend_frac <= '0;
      end else begin
         if (cfg_wr) begin
            pend_mode <= cfg_mode;
            pend_sel  <= cfg_sel;
            pend_div  <= cfg_div;
            pend_frac <= cfg_frac;
         end
         // A write landing on the apply edge is applied straight through.
         if (apply) begin
            {act_div, act_frac} <= new_cfg;
            cfg_pend            <= 1'b0;
         end else if (cfg_wr) begin
            cfg_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_baud_gen_prog.sv
// Bench for baud_gen_prog: expected tick_ovs / tick_bit spacings are queued
// as each scenario is set up and checked as the ticks arrive; preset and
// custom divisor decoding is checked from a vector table.
module tb_baud_gen_prog;

   localparam int DIV_W  = 16;
   localparam int FRAC_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              cfg_wr;
   logic              cfg_mode;
   logic [1:0]        cfg_sel;
   logic [DIV_W-1:0]  cfg_div;
   logic [FRAC_W-1:0] cfg_frac;
   logic              tick_ovs;
   logic              tick_bit;
   logic              cfg_pend;
   logic [DIV_W-1:0]  act_div;
   logic [FRAC_W-1:0] act_frac;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_ovs = 0;
   int last_bit = 0;
   int exp_q[$];
   int bit_q[$];
   bit watch651 = 1'b0;
   bit seen651  = 1'b0;

   typedef struct {
      logic              mode;
      logic [1:0]        sel;
      logic [DIV_W-1:0]  div;
      logic [FRAC_W-1:0] frac;
      int                exp_div;
      int                exp_frac;
   } vec_t;
   vec_t tbl[7];

   baud_gen_prog #(
      .CLK_HZ(100000000), .OVS(8), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
      .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_frac(cfg_frac),
      .tick_ovs(tick_ovs), .tick_bit(tick_bit), .cfg_pend(cfg_pend),
      .act_div(act_div), .act_frac(act_frac)
   );

   // Free-running clock and cycle count.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: compare tick spacings against the queued expectations.
   always @(negedge clk) begin
      if (tick_ovs) begin
         if (exp_q.size() > 0) chk("ovs_period", cyc - last_ovs, exp_q.pop_front());
         last_ovs = cyc;
      end
      if (tick_bit) begin
         chk("bit_with_ovs", tick_ovs, 1);
         if (bit_q.size() > 0) chk("bit_period", cyc - last_bit, bit_q.pop_front());
         last_bit = cyc;
      end
      if (watch651 && act_div == 16'd651) seen651 = 1'b1;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic push_n(input int n, input int p);
      repeat (n) exp_q.push_back(p);
   endtask

   task automatic pulse_wr(input logic m, input logic [1:0] s,
                           input logic [DIV_W-1:0] d, input logic [FRAC_W-1:0] f);
      cfg_mode = m; cfg_sel = s; cfg_div = d; cfg_frac = f; cfg_wr = 1'b1;
      step();
      cfg_wr = 1'b0;
   endtask

   // Wait until at most n periods remain queued (n=0 also drains bit_q).
   task automatic wait_q(input int n, input int max, input string name);
      int i;
      i = 0;
      while ((exp_q.size() > n || (n == 0 && bit_q.size() > 0)) && i < max) begin
         step();
         i++;
      end
      if (exp_q.size() > n || (n == 0 && bit_q.size() > 0)) begin
         checks++;
         failures++;
         $display("FAIL %s: timeout with %0d periods and %0d bits outstanding",
                  name, exp_q.size(), bit_q.size());
         exp_q.delete();
         bit_q.delete();
      end
   endtask

   initial begin
      int n;
      tbl[0] = '{1'b0, 2'd0, 16'd777,   4'd9,  1302,  1};
      tbl[1] = '{1'b0, 2'd1, 16'd777,   4'd9,  651,   1};
      tbl[2] = '{1'b0, 2'd2, 16'd777,   4'd9,  217,   0};
      tbl[3] = '{1'b0, 2'd3, 16'd777,   4'd9,  108,   8};
      tbl[4] = '{1'b1, 2'd0, 16'd5,     4'd3,  5,     3};
      tbl[5] = '{1'b1, 2'd2, 16'hFFFF,  4'd15, 65535, 15};
      tbl[6] = '{1'b1, 2'd0, 16'd0,     4'd0,  0,     0};

      rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_mode = 1'b0;
      cfg_sel = 2'd0; cfg_div = '0; cfg_frac = '0;
      idle(3);
      chk("rst_tick_ovs", tick_ovs, 0);
      chk("rst_tick_bit", tick_bit, 0);
      chk("rst_cfg_pend", cfg_pend, 0);
      chk("rst_act_div", act_div, 1302);
      chk("rst_act_frac", act_frac, 1);
      rst = 1'b0;
      idle(2);

      // Preset 0 from enable: sixteen 1302-cycle periods, then the carry period.
      push_n(16, 1302);
      exp_q.push_back(1303);
      bit_q.push_back(10416);
      bit_q.push_back(10416);
      last_ovs = cyc; last_bit = cyc; en = 1'b1;
      wait_q(0, 30000, "preset0_run");

      // Switch to 115200 mid-bit; old periods finish out the bit.
      idle(100);
      pulse_wr(1'b0, 2'd3, 16'd0, 4'd0);
      chk("s115_pend", cfg_pend, 1);
      chk("s115_old_div", act_div, 1302);
      push_n(7, 1302);
      for (int k = 1; k <= 24; k++) exp_q.push_back(108 + ((k >= 3 && (k % 2) == 1) ? 1 : 0));
      bit_q.push_back(10417);
      bit_q.push_back(867);
      bit_q.push_back(868);
      bit_q.push_back(868);
      wait_q(24, 12000, "s115_apply");
      chk("s115_div", act_div, 108);
      chk("s115_frac", act_frac, 8);
      chk("s115_pend_clr", cfg_pend, 0);
      wait_q(0, 4000, "s115_run");

      // Custom div=1 frac=0: clamped to a 2-cycle period.
      idle(50);
      pulse_wr(1'b1, 2'd0, 16'd1, 4'd0);
      chk("cust_pend", cfg_pend, 1);
      chk("cust_old_div", act_div, 108);
      for (int k = 25; k <= 32; k++) exp_q.push_back(108 + (k % 2));
      push_n(16, 2);
      bit_q.push_back(868);
      bit_q.push_back(16);
      bit_q.push_back(16);
      wait_q(16, 1500, "cust_apply");
      chk("cust_div", act_div, 1);
      chk("cust_frac", act_frac, 0);
      chk("cust_pend_clr", cfg_pend, 0);
      wait_q(0, 200, "cust_run");

      // Two writes inside one bit: only the last one lands.
      push_n(8, 2);
      push_n(16, 217);
      bit_q.push_back(16);
      bit_q.push_back(1736);
      bit_q.push_back(1736);
      watch651 = 1'b1;
      pulse_wr(1'b0, 2'd1, 16'd0, 4'd0);
      pulse_wr(1'b0, 2'd2, 16'd0, 4'd0);
      chk("lastwr_pend", cfg_pend, 1);
      chk("lastwr_old_div", act_div, 1);
      wait_q(16, 200, "lastwr_apply");
      chk("lastwr_div", act_div, 217);
      chk("lastwr_frac", act_frac, 0);
      chk("lastwr_pend_clr", cfg_pend, 0);
      wait_q(0, 4000, "lastwr_run");
      watch651 = 1'b0;
      chk("sel1_never_active", seen651, 0);

      // Drop en mid-period with a pending write; apply happens while idle.
      idle(100);
      pulse_wr(1'b0, 2'd3, 16'd0, 4'd0);
      chk("endrop_pend", cfg_pend, 1);
      en = 1'b0;
      step();
      chk("endrop_tick", tick_ovs, 0);
      chk("endrop_div", act_div, 108);
      chk("endrop_frac", act_frac, 8);
      chk("endrop_pend_clr", cfg_pend, 0);
      n = 0;
      repeat (20) begin
         step();
         n += int'(tick_ovs) + int'(tick_bit);
      end
      chk("endrop_no_ticks", n, 0);
      exp_q.push_back(108); exp_q.push_back(108); exp_q.push_back(109); exp_q.push_back(108);
      exp_q.push_back(109); exp_q.push_back(108); exp_q.push_back(109); exp_q.push_back(108);
      bit_q.push_back(867);
      last_ovs = cyc; last_bit = cyc; en = 1'b1;
      wait_q(0, 1500, "reenable_run");

      // Asynchronous reset mid-period with a pending write.
      idle(30);
      pulse_wr(1'b0, 2'd2, 16'd0, 4'd0);
      chk("rstmid_pend", cfg_pend, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_tick_ovs", tick_ovs, 0);
      chk("rstmid_tick_bit", tick_bit, 0);
      chk("rstmid_div", act_div, 1302);
      chk("rstmid_frac", act_frac, 1);
      chk("rstmid_pend", cfg_pend, 0);
      step();
      push_n(8, 1302);
      bit_q.push_back(10416);
      last_ovs = cyc; last_bit = cyc; rst = 1'b0;
      wait_q(0, 12000, "rstmid_run");
      chk("rstmid_div_kept", act_div, 1302);
      chk("rstmid_frac_kept", act_frac, 1);

      // Write coinciding with an apply edge (en low, pending set): written value wins.
      idle(20);
      pulse_wr(1'b0, 2'd1, 16'd0, 4'd0);
      chk("coinc_pend", cfg_pend, 1);
      en = 1'b0; cfg_mode = 1'b0; cfg_sel = 2'd2; cfg_wr = 1'b1;
      step();
      cfg_wr = 1'b0;
      chk("coinc_div", act_div, 217);
      chk("coinc_frac", act_frac, 0);
      chk("coinc_pend_clr", cfg_pend, 0);

      // Preset / custom decode table, applied while disabled.
      for (int i = 0; i < 7; i++) begin
         pulse_wr(tbl[i].mode, tbl[i].sel, tbl[i].div, tbl[i].frac);
         chk($sformatf("tbl%0d_pend", i), cfg_pend, 1);
         step();
         chk($sformatf("tbl%0d_div", i), act_div, tbl[i].exp_div);
         chk($sformatf("tbl%0d_frac", i), act_frac, tbl[i].exp_frac);
         chk($sformatf("tbl%0d_pend_clr", i), cfg_pend, 0);
      end

      // div=0 is clamped to a 2-cycle period.
      push_n(8, 2);
      bit_q.push_back(16);
      last_ovs = cyc; last_bit = cyc; en = 1'b1;
      wait_q(0, 100, "clamp_run");
      en = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
